// File: rtl/data_ram_banked_pkg.sv
// Shared types and helpers for the banked data RAM.
// Contents:
//   state_e        - clear-sweep FSM states
//   bytes_of/...   - geometry helpers derived from DATA_WIDTH / DEPTH_BYTES
//   BYTES, WORDS, IDX_LSB, IDX_MSB - geometry of the default 32-bit x 1 KiB build
//   lane_of        - big-endian byte offset -> lane number mapping
package data_ram_pkg;

    typedef enum logic {StClear, StReady} state_e;

    function automatic int unsigned bytes_of(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned words_of(input int unsigned data_width,
                                             input int unsigned depth_bytes);
        return depth_bytes / bytes_of(data_width);
    endfunction

    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefDepthBytes = 1024;
    localparam int unsigned BYTES   = bytes_of(DefDataWidth);
    localparam int unsigned WORDS   = words_of(DefDataWidth, DefDepthBytes);
    localparam int unsigned IDX_LSB = $clog2(BYTES);
    localparam int unsigned IDX_MSB = $clog2(DefDepthBytes) - 1;

    // Byte offset 0 (lowest address) lives in the most significant lane.
    function automatic int unsigned lane_of(input int unsigned offset,
                                            input int unsigned bytes);
        return bytes - 1 - offset;
    endfunction

endpackage

// File: rtl/data_ram_banked_if.sv
// CPU data-port bus for the banked data RAM.
// master: drives address, writedata, byteenable, write_en, read_en
// slave : drives readdata, readvalid, waitrequest, align_err
interface data_ram_banked_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    write_en;
    logic                    read_en;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readvalid;
    logic                    waitrequest;
    logic                    align_err;

    modport master (
        output address, writedata, byteenable, write_en, read_en,
        input  readdata, readvalid, waitrequest, align_err
    );

    modport slave (
        input  address, writedata, byteenable, write_en, read_en,
        output readdata, readvalid, waitrequest, align_err
    );
endinterface

// File: rtl/data_ram_banked_byte_lane.sv
// One 8-bit wide, Words-deep slice of the data RAM.
// Ports:
//   clk, reset_n      - clock, synchronous active-low reset (clears read register only)
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i      - read request; data registered into rdata_o
//   zero_i            - return 0 instead of array contents for this read
//   rdata_o           - registered read data
module data_ram_byte_lane #(
    parameter int unsigned Words = 16,
    localparam int unsigned Aw   = $clog2(Words)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic          zero_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [Words];
    logic [7:0] rdata_q;

    // No reset on the array: the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write contents when addressed in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= zero_i ? 8'h00 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram_banked.sv
// Word-organised, byte-addressed, big-endian data RAM with per-byte enables,
// one-cycle registered read and a hardware clear sweep after every reset.
// Ports:
//   clk      - clock
//   reset_n  - synchronous active-low reset; restarts the clear sweep
//   bus      - data_ram_banked_if.slave (address, writedata, byteenable,
//              write_en, read_en / readdata, readvalid, waitrequest, align_err)
// Build option: DATA_RAM_ALIGN_CHECK_EN suppresses misaligned accesses and
// pulses align_err; otherwise low address bits are ignored and align_err = 0.
module data_ram_banked
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input logic             clk,
    input logic             reset_n,
    data_ram_banked_if.slave bus
);
    localparam int unsigned Bytes  = bytes_of(DATA_WIDTH);
    localparam int unsigned Words  = words_of(DATA_WIDTH, DEPTH_BYTES);
    localparam int unsigned IdxLsb = $clog2(Bytes);
    localparam int unsigned IdxMsb = $clog2(DEPTH_BYTES) - 1;
    localparam int unsigned IdxW   = IdxMsb - IdxLsb + 1;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            wait_q, rvalid_q, aerr_q;

    logic [IdxW-1:0] idx;
    logic            clearing, rd_acc, wr_acc, misaligned;

    assign idx      = bus.address[IdxMsb:IdxLsb];
    assign clearing = (state_q == StClear);
    assign rd_acc   = !clearing && bus.read_en;
    assign wr_acc   = !clearing && bus.write_en;

    // Upper address bits wrap the address space.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[ADDR_WIDTH-1:IdxMsb+1];

`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign misaligned = |bus.address[IdxLsb-1:0];
`else
    assign misaligned = 1'b0;
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.address[IdxLsb-1:0];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IdxW'(Words - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: ;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StClear;
            ptr_q    <= '0;
            wait_q   <= 1'b1;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wait_q   <= (state_d == StClear);
            rvalid_q <= rd_acc;
            aerr_q   <= (rd_acc || wr_acc) && misaligned;
        end
    end

    for (genvar i = 0; i < Bytes; i++) begin : g_lane
        logic            we;
        logic [IdxW-1:0] waddr;
        logic [7:0]      wdata;

        // The sweep owns the write port while clearing.
        assign we    = reset_n && (clearing || (wr_acc && !misaligned && bus.byteenable[i]));
        assign waddr = clearing ? ptr_q : idx;
        assign wdata = clearing ? 8'h00 : bus.writedata[8*i +: 8];

        data_ram_byte_lane #(
            .Words (Words)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (we),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (rd_acc),
            .zero_i  (misaligned),
            .raddr_i (idx),
            .rdata_o (bus.readdata[8*i +: 8])
        );
    end

    assign bus.readvalid   = rvalid_q;
    assign bus.waitrequest = wait_q;
    assign bus.align_err   = aerr_q;
endmodule

// File: doc/data_ram_banked.md
Name: data_ram_banked

Overview:
Parametrised successor to the 32-bit Harvard data RAM. Word-organised, byte-addressed, big-endian memory with per-byte write enables and a registered read (readvalid strobe). A hardware clear sweep zeroes the whole array after every reset, so simulation-only initialisation is no longer needed. It sits on the CPU data port; the CPU stalls on waitrequest.

Parameters:
ADDR_WIDTH, 32, width of the byte address bus.
DATA_WIDTH, 32, word width; must be a multiple of 8. BYTES = DATA_WIDTH/8.
DEPTH_BYTES, 1024, capacity in bytes; power of 2, multiple of BYTES. WORDS = DEPTH_BYTES/BYTES.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset_n  in  1  synchronous, active-low reset.
address  in  ADDR_WIDTH  byte address of the access.
writedata  in  DATA_WIDTH  write data; writedata[DATA_WIDTH-1 -: 8] goes to the lowest byte address.
byteenable  in  BYTES  byteenable[i] enables writedata[8i+7:8i].
write_en  in  1  write request.
read_en  in  1  read request.
readdata  out  DATA_WIDTH  registered read data.
readvalid  out  1  one-cycle pulse: readdata holds the result of a read.
waitrequest  out  1  high = requests ignored (clear sweep in progress).
align_err  out  1  misalignment pulse (optional feature; otherwise tied 0).

Behaviour:
- Reset (reset_n=0 at an edge): readdata=0, readvalid=0, waitrequest=1, align_err=0, state=CLEAR, clear_ptr=0.
- FSM, 2 states:
  - CLEAR: each cycle writes 0 to word clear_ptr, then clear_ptr++. When clear_ptr==WORDS-1, the next state is READY.
  - READY: terminal until the next reset.
- waitrequest is a registered output, high exactly while in CLEAR. It falls WORDS cycles after the first edge with reset_n=1.
- In CLEAR, read_en and write_en are ignored: no write, no readvalid.
- Address decode: word index = address[log2(DEPTH_BYTES)-1 : log2(BYTES)].
  - Upper bits are ignored, so addresses wrap modulo DEPTH_BYTES.
  - Low log2(BYTES) bits are ignored (forced word alignment), except as noted under Optional Feature.
- Write (READY, write_en=1): at the edge, each lane i with byteenable[i]=1 is updated. byteenable=0 means no change.
- Read (READY, read_en=1): at the edge, readdata <= word and readvalid <= 1, so latency is 1 cycle.
  - readvalid is 0 in any cycle following no accepted read.
  - readdata holds its last value when no read is accepted.
- Simultaneous read and write to the same word: the read returns the pre-write contents (read-before-write). The new data is visible to the next read.
- Back-to-back reads are accepted every cycle (full throughput).
- Reset mid-sweep or mid-access: the sweep restarts from word 0, a pending readvalid is dropped, and all contents end up zero.

Optional Feature:
Macro: DATA_RAM_ALIGN_CHECK_EN
- Defined: an accepted access whose address low log2(BYTES) bits are nonzero is suppressed (no write). For such a read, readvalid pulses with readdata=0. align_err pulses 1 cycle after the access, coincident with readvalid for reads.
- Undefined: low bits are silently ignored, align_err is constant 0, and no check logic is synthesised.

Decomposition:
- Package data_ram_pkg:
  - state enum {CLEAR, READY};
  - function lane_of(byte offset) giving the big-endian mapping (lane = BYTES-1-offset);
  - localparams BYTES, WORDS, IDX_LSB, IDX_MSB derived from the parameters.
- One natural sub-module: data_ram_byte_lane, an 8-bit x WORDS array with its own write enable and registered read, instantiated BYTES times via generate. The clear FSM drives all lanes.

Test Plan (DATA_WIDTH=32, DEPTH_BYTES=64 -> WORDS=16):
1. Release reset -> waitrequest=1 for exactly 16 cycles, then 0. Read addresses 0x00..0x3C -> every readdata=0x00000000, readvalid pulses each cycle after read_en.
2. Write 0xDEADBEEF at 0x08 with be=4'b1111, then read 0x08 -> one cycle later readvalid=1, readdata=0xDEADBEEF.
3. Write 0x11223344 at 0x08 with be=4'b0100 -> read returns 0xDE22BEEF. A write with be=4'b0000 leaves it 0xDE22BEEF.
4. Same-cycle read+write at 0x08 with data 0xCAFEF00D -> readdata=0xDE22BEEF; the next read returns 0xCAFEF00D.
5. Write 0x12345678 at 0x48 -> read at 0x08 returns 0x12345678 (wrap-around).
6. Assert reset_n=0 for 1 cycle mid-sweep and again mid-read -> waitrequest re-asserts for 16 cycles, pending readvalid is not produced, and the read of 0x08 returns 0. With DATA_RAM_ALIGN_CHECK_EN defined, a read at 0x09 -> readvalid=1, readdata=0, align_err=1.
